// File: rtl/line_capture_buffer.sv
// line_capture_buffer
//   Watches the camera byte stream, captures one selected line of a frame
//   into an internal RAM and then hands it out byte-by-byte on a
//   getData/data/dataValid handshake.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start, stop       : one-cycle control pulses (stop has priority)
//   configuration     : [11:0] lineLength, [23:12] lineIndex, [24] continuous
//   vsync, href       : camera frame / line qualifiers
//   pixValid, pixData : camera byte strobe and byte
//   lineCaptured      : a captured line is waiting to be read out
//   getData           : request next byte; data/dataValid follow one cycle later
//   busy              : not IDLE
//   shortLine         : captured line ended early on href falling
module line_capture_buffer #(
    parameter int BUFFER_DEPTH = 2048,
    parameter int ADDR_WIDTH   = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] configuration,
    input  logic        vsync,
    input  logic        href,
    input  logic        pixValid,
    input  logic [7:0]  pixData,
    output logic        lineCaptured,
    input  logic        getData,
    output logic [7:0]  data,
    output logic        dataValid,
    output logic        busy,
    output logic        shortLine
);
    // Lengths/pointers need one extra bit so they can hold BUFFER_DEPTH itself.
    localparam int LW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, WAIT_FRAME, WAIT_LINE, CAPTURE, READY} state_t;

    state_t          r_state;
    logic            r_vsync_d, r_href_d;
    logic [11:0]     r_line_cnt;
    logic [LW-1:0]   r_len, r_wr_ptr, r_rd_ptr, r_cap_len;
    logic [11:0]     r_index;
    logic            r_cont;
    logic            r_line_captured, r_short, r_dvalid;
    logic [7:0]      r_data;
    logic [7:0]      r_mem [BUFFER_DEPTH];

    logic            w_vsync_rise, w_href_fall, w_line_hit, w_cap_wr, w_last_wr;
    logic            w_we, w_rd, w_rd_last;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [11:0]     w_cfg_len;
    logic [LW-1:0]   w_cfg_len_clamped;
    logic            w_unused_cfg;

    assign w_unused_cfg = &{1'b0, configuration[31:25]};

    assign w_vsync_rise = vsync & ~r_vsync_d;
    assign w_href_fall  = r_href_d & ~href;

    assign w_cfg_len = configuration[11:0];
    assign w_cfg_len_clamped = ({20'd0, w_cfg_len} > 32'(BUFFER_DEPTH)) ?
                               LW'(BUFFER_DEPTH) : LW'(w_cfg_len);

    // The selected line starts: a byte on this very cycle lands at address 0.
    assign w_line_hit = (r_state == WAIT_LINE) && href && (r_line_cnt == r_index);
    // In CAPTURE wr_ptr is always below r_len, so every strobe is stored.
    assign w_cap_wr   = (r_state == CAPTURE) && !w_vsync_rise && pixValid && href;
    assign w_last_wr  = w_cap_wr && (LW'(r_wr_ptr + LW'(1)) == r_len);

    assign w_we    = !stop && ((w_line_hit && pixValid) || w_cap_wr);
    assign w_waddr = w_line_hit ? '0 : r_wr_ptr[ADDR_WIDTH-1:0];

    assign w_rd      = (r_state == READY) && getData && !stop;
    assign w_rd_last = w_rd && (r_rd_ptr == LW'(r_cap_len - LW'(1)));

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= pixData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_vsync_d       <= 1'b0;
            r_href_d        <= 1'b0;
            r_line_cnt      <= '0;
            r_len           <= '0;
            r_index         <= '0;
            r_cont          <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_cap_len       <= '0;
            r_line_captured <= 1'b0;
            r_short         <= 1'b0;
            r_dvalid        <= 1'b0;
            r_data          <= 8'h00;
        end else begin
            r_vsync_d <= vsync;
            r_href_d  <= href;
            if (w_vsync_rise)
                r_line_cnt <= '0;
            else if (w_href_fall && r_line_cnt != 12'hFFF)
                r_line_cnt <= r_line_cnt + 12'd1;

            r_dvalid <= 1'b0;

            if (stop) begin
                r_state         <= IDLE;
                r_wr_ptr        <= '0;
                r_rd_ptr        <= '0;
                r_line_captured <= 1'b0;
                r_short         <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start && w_cfg_len != 12'd0) begin
                            r_len    <= w_cfg_len_clamped;
                            r_index  <= configuration[23:12];
                            r_cont   <= configuration[24];
                            r_short  <= 1'b0;
                            r_wr_ptr <= '0;
                            r_rd_ptr <= '0;
                            r_state  <= WAIT_FRAME;
                        end
                    end
                    // Waiting for a frame start means capture never begins mid-line.
                    WAIT_FRAME: begin
                        if (w_vsync_rise) r_state <= WAIT_LINE;
                    end
                    WAIT_LINE: begin
                        if (w_line_hit) begin
                            if (pixValid) begin
                                r_wr_ptr <= LW'(1);
                                if (r_len == LW'(1)) begin
                                    r_state         <= READY;
                                    r_cap_len       <= LW'(1);
                                    r_line_captured <= 1'b1;
                                    r_short         <= 1'b0;
                                end else begin
                                    r_state <= CAPTURE;
                                end
                            end else begin
                                r_state <= CAPTURE;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (w_vsync_rise) begin
                            r_state  <= WAIT_LINE;
                            r_wr_ptr <= '0;
                        end else if (w_cap_wr) begin
                            r_wr_ptr <= LW'(r_wr_ptr + LW'(1));
                            if (w_last_wr) begin
                                r_state         <= READY;
                                r_cap_len       <= r_len;
                                r_line_captured <= 1'b1;
                                r_short         <= 1'b0;
                            end
                        end else if (w_href_fall) begin
                            if (r_wr_ptr == '0) begin
                                // Line ended with nothing stored: wait for the next frame.
                                r_state <= WAIT_FRAME;
                            end else begin
                                r_state         <= READY;
                                r_cap_len       <= r_wr_ptr;
                                r_line_captured <= 1'b1;
                                r_short         <= 1'b1;
                            end
                        end
                    end
                    READY: begin
                        if (w_rd) begin
                            r_data   <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
                            r_dvalid <= 1'b1;
                            r_rd_ptr <= LW'(r_rd_ptr + LW'(1));
                            if (w_rd_last) begin
                                r_line_captured <= 1'b0;
                                r_rd_ptr        <= '0;
                                r_wr_ptr        <= '0;
                                r_state         <= r_cont ? WAIT_FRAME : IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign lineCaptured = r_line_captured;
    assign data         = r_data;
    assign dataValid    = r_dvalid;
    assign busy         = (r_state != IDLE);
    assign shortLine    = r_short;

endmodule

// File: tb/tb_line_capture_buffer.sv
module tb_line_capture_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, stop = 1'b0, getData = 1'b0;
    logic [31:0] configuration = '0;
    logic        vsync = 1'b0, href = 1'b0, pixValid = 1'b0;
    logic [7:0]  pixData = '0;
    logic        lineCaptured, dataValid, busy, shortLine;
    logic [7:0]  data;

    line_capture_buffer dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .configuration(configuration), .vsync(vsync), .href(href),
        .pixValid(pixValid), .pixData(pixData), .lineCaptured(lineCaptured),
        .getData(getData), .data(data), .dataValid(dataValid),
        .busy(busy), .shortLine(shortLine)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    int nrx = 0;
    int rise_cyc = -1, exp_rise = -1;
    logic lc_prev = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every dataValid pops one expected byte.
    always @(negedge clk) begin
        if (dataValid === 1'b1) begin
            checks++;
            nrx++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL data_unexpected got %h expected none", data);
            end else begin
                exp_b = exp_q.pop_front();
                if (data !== exp_b) begin
                    errors++;
                    $display("FAIL data got %h expected %h", data, exp_b);
                end
            end
        end
        if (lineCaptured === 1'b1 && lc_prev !== 1'b1) rise_cyc = cyc;
        lc_prev = lineCaptured;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] cfg(input int len, input int idx, input bit cont);
        return {7'd0, cont, 12'(idx), 12'(len)};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // One camera frame: nl lines of bl bytes, byte = base + 16*line + col.
    // ev_kind: 1 start(ev_cfg), 2 stop, 3 reset, fired at (ev_line, ev_col).
    task automatic cam_frame(input int nl, input int bl, input int base,
                             input int cap_line, input int cap_len, input bit cap_full,
                             input int ev_line, input int ev_col, input int ev_kind,
                             input logic [31:0] ev_cfg);
        bit pend_stop = 0, pend_rst = 0;
        tick(); start = 0; stop = 0; vsync = 1;
        tick(); tick(); vsync = 0;
        repeat (3) tick();
        for (int l = 0; l < nl; l++) begin
            for (int c = 0; c < bl; c++) begin
                tick();
                start = 0; stop = 0;
                if (pend_stop) begin
                    pend_stop = 0;
                    checks++;
                    if (busy !== 1'b0 || lineCaptured !== 1'b0) begin
                        errors++;
                        $display("FAIL stop_idle got busy=%b lc=%b expected 0 0", busy, lineCaptured);
                    end
                end
                if (pend_rst) begin
                    pend_rst = 0;
                    reset = 0;
                end
                href = 1; pixValid = 1; pixData = 8'(base + 16 * l + c);
                if (l == cap_line && c < cap_len) exp_q.push_back(8'(base + 16 * l + c));
                if (l == cap_line && cap_full && c == cap_len - 1) exp_rise = cyc + 1;
                if (l == ev_line && c == ev_col) begin
                    if (ev_kind == 1) begin
                        start = 1; configuration = ev_cfg;
                    end else if (ev_kind == 2) begin
                        stop = 1; pend_stop = 1;
                    end else if (ev_kind == 3) begin
                        reset = 1; pend_rst = 1;
                        #1;
                        checks++;
                        if ({lineCaptured, data, dataValid, busy, shortLine} !== 12'h000) begin
                            errors++;
                            $display("FAIL reset_mid got lc=%b d=%h dv=%b busy=%b sl=%b expected all 0",
                                     lineCaptured, data, dataValid, busy, shortLine);
                        end
                    end
                end
            end
            tick();
            start = 0; stop = 0; href = 0; pixValid = 0;
            if (pend_rst) begin pend_rst = 0; reset = 0; end
            if (l == cap_line && !cap_full) exp_rise = cyc + 1;
            repeat (3) tick();
        end
    endtask

    // n getData requests, back-to-back when gap=0; then checks last-byte timing.
    task automatic read_bytes(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            tick(); getData = 1;
            if (gap && i < n - 1) begin tick(); getData = 0; end
        end
        tick();
        checks++;
        if (dataValid !== 1'b1 || lineCaptured !== 1'b0) begin
            errors++;
            $display("FAIL last_read got dv=%b lc=%b expected 1 0", dataValid, lineCaptured);
        end
        getData = 1;   // extra request, must be ignored
        tick(); getData = 0;
        checks++;
        if (dataValid !== 1'b0) begin
            errors++;
            $display("FAIL extra_get got dv=%b expected 0", dataValid);
        end
    endtask

    task automatic arm(input logic [31:0] c);
        tick(); configuration = c; start = 1;
        tick(); start = 0;
    endtask

    task automatic check_rise(input string name);
        checks++;
        if (rise_cyc !== exp_rise || exp_rise < 0) begin
            errors++;
            $display("FAIL %s_rise got %0d expected %0d", name, rise_cyc, exp_rise);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1;
        repeat (2) tick();
        reset = 0;
        tick();
        checks++;
        if ({lineCaptured, data, dataValid, busy, shortLine} !== 12'h000) begin
            errors++;
            $display("FAIL reset got lc=%b d=%h dv=%b busy=%b sl=%b expected all 0",
                     lineCaptured, data, dataValid, busy, shortLine);
        end
    endtask

    task automatic test_full_line();
        arm(cfg(16, 2, 0));
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL full_busy got %b expected 1", busy); end
        rise_cyc = -1; exp_rise = -1; nrx = 0;
        cam_frame(4, 20, 0, 2, 16, 1, -1, -1, 0, '0);
        check_rise("full");
        checks++;
        if (shortLine !== 1'b0 || lineCaptured !== 1'b1) begin
            errors++; $display("FAIL full_flags got sl=%b lc=%b expected 0 1", shortLine, lineCaptured);
        end
        read_bytes(16, 1);
        checks++;
        if (nrx != 16 || exp_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL full_done got n=%0d busy=%b expected 16 0", nrx, busy);
        end
    endtask

    task automatic test_short_line();
        arm(cfg(32, 1, 0));
        rise_cyc = -1; exp_rise = -1; nrx = 0;
        cam_frame(3, 10, 8'h40, 1, 10, 0, -1, -1, 0, '0);
        check_rise("short");
        checks++;
        if (shortLine !== 1'b1) begin errors++; $display("FAIL short_flag got %b expected 1", shortLine); end
        read_bytes(10, 0);
        checks++;
        if (nrx != 10 || exp_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL short_done got n=%0d busy=%b expected 10 0", nrx, busy);
        end
    endtask

    task automatic test_midline_arm();
        rise_cyc = -1; exp_rise = -1; nrx = 0;
        cam_frame(3, 12, 0, -1, 0, 0, 1, 4, 1, cfg(8, 1, 0));
        checks++;
        if (rise_cyc != -1 || busy !== 1'b1 || nrx != 0) begin
            errors++; $display("FAIL midarm_early got rise=%0d busy=%b expected -1 1", rise_cyc, busy);
        end
        cam_frame(3, 12, 8'h80, 1, 8, 1, -1, -1, 0, '0);
        check_rise("midarm");
        read_bytes(8, 0);
        checks++;
        if (nrx != 8 || exp_q.size() != 0) begin
            errors++; $display("FAIL midarm_count got %0d expected 8", nrx);
        end
    endtask

    task automatic test_abort();
        // stop during CAPTURE
        arm(cfg(8, 0, 0));
        nrx = 0;
        cam_frame(2, 12, 8'h10, -1, 0, 0, 0, 3, 2, '0);
        tick(); getData = 1;
        tick(); getData = 0;
        checks++;
        if (dataValid !== 1'b0 || busy !== 1'b0 || nrx != 0) begin
            errors++; $display("FAIL abort_cap got dv=%b busy=%b expected 0 0", dataValid, busy);
        end
        // stop during READY after three bytes
        arm(cfg(8, 0, 0));
        cam_frame(2, 12, 8'h20, 0, 8, 1, -1, -1, 0, '0);
        repeat (3) begin tick(); getData = 1; end
        tick(); getData = 0;
        tick();
        exp_q.delete();
        checks++;
        if (nrx != 3) begin errors++; $display("FAIL abort_partial got %0d expected 3", nrx); end
        stop = 1;
        tick(); stop = 0;
        checks++;
        if (busy !== 1'b0 || lineCaptured !== 1'b0 || shortLine !== 1'b0 || data !== 8'h22) begin
            errors++;
            $display("FAIL abort_ready got busy=%b lc=%b sl=%b d=%h expected 0 0 0 22",
                     busy, lineCaptured, shortLine, data);
        end
        getData = 1;
        tick(); getData = 0;
        checks++;
        if (dataValid !== 1'b0 || data !== 8'h22) begin
            errors++; $display("FAIL abort_get got dv=%b d=%h expected 0 22", dataValid, data);
        end
        // reset mid-capture
        arm(cfg(8, 0, 0));
        cam_frame(2, 12, 8'h30, -1, 0, 0, 0, 3, 3, '0);
        checks++;
        if (busy !== 1'b0 || lineCaptured !== 1'b0) begin
            errors++; $display("FAIL reset_after got busy=%b lc=%b expected 0 0", busy, lineCaptured);
        end
    endtask

    task automatic test_continuous();
        arm(cfg(8, 0, 1));
        for (int f = 0; f < 3; f++) begin
            rise_cyc = -1; exp_rise = -1; nrx = 0;
            cam_frame(3, 10, f * 8'h50, 0, 8, 1, -1, -1, 0, '0);
            check_rise("cont");
            arm(cfg(2, 0, 0));   // ignored while READY
            read_bytes(8, 0);
            checks++;
            if (nrx != 8 || exp_q.size() != 0 || busy !== 1'b1) begin
                errors++; $display("FAIL cont_frame%0d got n=%0d busy=%b expected 8 1", f, nrx, busy);
            end
        end
        tick(); stop = 1;
        tick(); stop = 0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop got %b expected 0", busy); end
    endtask

    task automatic test_clamp();
        arm(cfg(0, 0, 0));
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL zero_len got busy=%b expected 0", busy); end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL zero_len2 got busy=%b expected 0", busy); end
        arm(cfg(4095, 0, 0));
        rise_cyc = -1; exp_rise = -1; nrx = 0;
        cam_frame(1, 2100, 0, 0, 2048, 1, -1, -1, 0, '0);
        check_rise("clamp");
        checks++;
        if (shortLine !== 1'b0) begin errors++; $display("FAIL clamp_short got %b expected 0", shortLine); end
        read_bytes(2048, 0);
        checks++;
        if (nrx != 2048 || exp_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL clamp_count got n=%0d busy=%b expected 2048 0", nrx, busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_short_line();
        test_midline_arm();
        test_abort();
        test_continuous();
        test_clamp();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
